dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters: the processor (load/store) and the display scanner (board-region reads for the VGA path).
- The processor has priority. A starvation counter guarantees the scanner a slot within MAX_CPU_RUN cycles.
- Sits between processor/scanner and dmem, on the dmem clock domain.
- Also flags processor writes into the board region so the scanner knows to refresh.

Parameters:
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, dmem data width
- MAX_CPU_RUN, 4, max consecutive CPU grants while a scanner request waits (range 1..15)
- BOARD_BASE, 12'h100, first word of the board region
- BOARD_WORDS, 200, number of words in the board region

Ports:
- clock  in  1  dmem-domain clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  processor requests an access this cycle
- cpu_wren  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  processor word address
- cpu_data  in  DATA_W  store data
- cpu_stall  out  1  request not granted this cycle; processor holds all cpu_* inputs stable
- cpu_valid  out  1  cpu_q holds load data for the load granted last cycle
- cpu_q  out  DATA_W  load data
- vga_req  in  1  scanner read request, held until granted
- vga_addr  in  ADDR_W  scanner word address
- vga_gnt  out  1  scanner request granted this cycle
- vga_valid  out  1  vga_q holds data for the read granted last cycle
- vga_q  out  DATA_W  scanner read data
- board_dirty  out  1  sticky: a processor store hit the board region since the last clear
- dirty_clr  in  1  scanner clears board_dirty (start of frame)
- mem_addr  out  ADDR_W  to dmem
- mem_data  out  DATA_W  to dmem
- mem_wren  out  1  to dmem
- mem_q  in  DATA_W  from dmem, valid one cycle after the address

Behaviour:
- Reset:
  - Every output is 0.
  - Starvation counter is 0; last-owner register is NONE.
  - A reset mid-operation discards any in-flight read: no valid pulse follows.
- Grant decision (combinational each cycle):
  - cpu_req only: CPU granted.
  - vga_req only: VGA granted.
  - Both, counter < MAX_CPU_RUN: CPU granted, counter increments.
  - Both, counter == MAX_CPU_RUN: VGA granted, cpu_stall = 1, counter clears.
  - Counter clears whenever vga_req = 0 or VGA is granted. It saturates at MAX_CPU_RUN and never wraps.
- Driving dmem:
  - mem_addr, mem_data and mem_wren are driven combinationally from the winner.
  - mem_wren = cpu_wren only on a CPU grant; 0 otherwise. The scanner never writes.
  - Idle cycles: mem_addr keeps its previous value, mem_wren = 0.
- Read latency: one cycle.
  - A registered owner tag (NONE / CPU_RD / VGA_RD) is set on the grant cycle.
  - The next cycle, mem_q is routed to cpu_q or vga_q and exactly one of cpu_valid / vga_valid pulses for one cycle.
  - CPU stores set the tag to NONE: no cpu_valid.
  - The non-owner q output holds its last value.
- Back-to-back grants to alternating owners are legal every cycle. Valid pulses therefore alternate with no bubble.
- board_dirty:
  - Set on the cycle after a granted CPU store with BOARD_BASE <= cpu_addr < BOARD_BASE + BOARD_WORDS.
  - Comparison is unsigned and ADDR_W+1 bits wide, so BASE + WORDS cannot overflow.
  - dirty_clr clears it on the next edge.
  - If set and clear occur in the same cycle, set wins: the store is not lost.
- Stall protocol:
  - cpu_stall is combinational and only ever asserted while cpu_req = 1.
  - A stalled CPU access is retried next cycle with counter = 0, so it is always granted.
  - vga_gnt is combinational. The scanner advances its address only on vga_gnt.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - owner encoding (NONE = 2'd0, CPU_RD = 2'd1, VGA_RD = 2'd2)
  - BOARD_BASE / BOARD_WORDS defaults, shared with the scanner and software memory map
  - ADDR_W / DATA_W defaults
- One sub-module, arb_starve_ctr: saturating counter plus the compare that produces the force-VGA decision.
- Grant mux, owner tag and dirty flag stay in dmem_arbiter.

Test Plan:
- Reset then idle: all outputs 0. Then cpu_req=1, cpu_wren=0, cpu_addr=12'h005, dmem[5]=32'hDEADBEEF: mem_addr=5 the same cycle; the next cycle cpu_valid=1 and cpu_q=32'hDEADBEEF; vga_valid stays 0.
- Starvation: cpu_req and vga_req both held high, MAX_CPU_RUN=4: CPU granted for cycles 1-4; cycle 5 gives vga_gnt=1 and cpu_stall=1; cycle 6 grants CPU with the held address; the sequence repeats with period 5.
- Alternating reads: CPU load of addr 3 (data 32'h11), then VGA read of addr 12'h100 (data 32'h22) on consecutive cycles: cpu_valid with 32'h11, then vga_valid with 32'h22 the following cycle, no gap.
- Dirty flag boundaries: stores to 12'h0FF and 12'h1C8 leave board_dirty=0; a store to 12'h1C7 sets board_dirty=1 one cycle later. Store to 12'h120 coincident with dirty_clr=1: board_dirty stays 1. A lone dirty_clr then gives 0.
- Reset mid-read: VGA read granted, reset=1 on the next edge: vga_valid never asserts, counter=0, board_dirty=0.
- Scanner-only traffic: vga_req=1 for 8 cycles with cpu_req=0: vga_gnt=1 every cycle, 8 vga_valid pulses, mem_wren=0 throughout, cpu_stall=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared defaults and owner encoding for the dmem arbiter, scanner and memory map.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF      = 12;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned MAX_CPU_RUN_DEF = 4;
  localparam int unsigned BOARD_BASE_DEF  = 32'h100;
  localparam int unsigned BOARD_WORDS_DEF = 200;
  localparam int unsigned CTR_W           = 4;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_VGA_RD = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive CPU wins while the scanner waits; forces a scanner slot at the limit.
module arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_CPU_RUN = MAX_CPU_RUN_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_req_i,
  input  logic vga_req_i,
  output logic force_vga_o
);

  localparam logic [CTR_W-1:0] RUN_MAX = CTR_W'(MAX_CPU_RUN);

  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max      = (cnt_q == RUN_MAX);
  assign force_vga_o = cpu_req_i & vga_req_i & at_max;

  // Clears on no scanner request or a scanner grant, so it can never pass RUN_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (!vga_req_i || !cpu_req_i || at_max) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between processor (priority) and display scanner,
// routes one-cycle read data back to the owner, and flags board-region stores.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MAX_CPU_RUN = MAX_CPU_RUN_DEF,
  parameter int unsigned BOARD_BASE  = BOARD_BASE_DEF,
  parameter int unsigned BOARD_WORDS = BOARD_WORDS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_stall,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_q,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_q,
  output logic              board_dirty,
  input  logic              dirty_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int unsigned AX_W = ADDR_W + 1;
  localparam logic [AX_W-1:0] BOARD_LO = AX_W'(BOARD_BASE);
  localparam logic [AX_W-1:0] BOARD_HI = AX_W'(BOARD_BASE + BOARD_WORDS);

  logic              force_vga;
  logic              cpu_gnt;
  logic              board_hit;
  logic [AX_W-1:0]   cpu_addr_x;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] cpu_hold_q, vga_hold_q;
  logic              dirty_q, dirty_d;

  arb_starve_ctr #(
    .MAX_CPU_RUN (MAX_CPU_RUN)
  ) u_starve (
    .clk_i       (clock),
    .rst_i       (reset),
    .cpu_req_i   (cpu_req),
    .vga_req_i   (vga_req),
    .force_vga_o (force_vga)
  );

  // Grant mux: CPU wins unless the starvation limit hands the slot to the scanner.
  always_comb begin
    cpu_gnt   = 1'b0;
    vga_gnt   = 1'b0;
    cpu_stall = 1'b0;
    mem_addr  = last_addr_q;
    mem_data  = '0;
    mem_wren  = 1'b0;
    owner_d   = OWN_NONE;
    if (cpu_req && !force_vga) begin
      cpu_gnt  = 1'b1;
      mem_addr = cpu_addr;
      mem_data = cpu_data;
      mem_wren = cpu_wren;
      owner_d  = cpu_wren ? OWN_NONE : OWN_CPU_RD;
    end else if (vga_req) begin
      vga_gnt   = 1'b1;
      cpu_stall = cpu_req;
      mem_addr  = vga_addr;
      owner_d   = OWN_VGA_RD;
    end
  end

  // Widened compare so BOARD_BASE + BOARD_WORDS cannot wrap.
  assign cpu_addr_x = {1'b0, cpu_addr};
  assign board_hit  = cpu_gnt && cpu_wren &&
                      (cpu_addr_x >= BOARD_LO) && (cpu_addr_x < BOARD_HI);

  // A store in the same cycle as a clear must keep the flag set.
  always_comb begin
    dirty_d = dirty_q;
    if (board_hit) begin
      dirty_d = 1'b1;
    end else if (dirty_clr) begin
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      last_addr_q <= '0;
      cpu_hold_q  <= '0;
      vga_hold_q  <= '0;
      dirty_q     <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_addr_q <= mem_addr;
      dirty_q     <= dirty_d;
      if (owner_q == OWN_CPU_RD) cpu_hold_q <= mem_q;
      if (owner_q == OWN_VGA_RD) vga_hold_q <= mem_q;
    end
  end

  assign cpu_valid   = (owner_q == OWN_CPU_RD);
  assign vga_valid   = (owner_q == OWN_VGA_RD);
  assign cpu_q       = cpu_valid ? mem_q : cpu_hold_q;
  assign vga_q       = vga_valid ? mem_q : vga_hold_q;
  assign board_dirty = dirty_q;

endmodule
